// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// funct codes and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    BNEX   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: maps the controller's aluop plus the R-type
// funct field onto the 3-bit ALU operation.
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALU_ADD;
          FUNCT_SUB: alucontrol_o = ALU_SUB;
          FUNCT_AND: alucontrol_o = ALU_AND;
          FUNCT_OR:  alucontrol_o = ALU_OR;
          FUNCT_SLT: alucontrol_o = ALU_SLT;
          default:   alucontrol_o = ALU_AND;
        endcase
      end
      // 00 and the unused 11 both mean add
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath. Define
// MULTICYCLE_CTRL_BNE_EN to add the BNEX state for bne (op 000101).
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       pcwrite;
  logic       branch;
  logic       nbranch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    nbranch  = 1'b0;
    aluop    = ALUOP_ADD;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = BNEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        state_d = MEMWB;
        iord    = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        state_d = ALUWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        state_d = ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      BNEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        nbranch = 1'b1;
      end
`endif
      // unused codes behave like an idle FETCH: everything low, back to FETCH
      default: state_d = FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero) | (nbranch & ~zero);
  assign state = state_q;

  alu_dec u_alu_dec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the
// FSM against hand-written state sequences and per-state strobe masks.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp  = 0;
  int    n_fail = 0;
  string cur    = "";

  // scoreboard: expected state sequence plus strobes seen, indexed by state
  logic [3:0]  exp_q[$];
  logic [15:0] m_regwrite, m_memtoreg, m_memwrite, m_iord, m_regdst, m_pcen, m_irwrite;
  logic [2:0]  alu_seen[16];
  int          memwrite_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // walk the FSM through the queued states, sampling 1 time unit after each edge
  task automatic walk();
    int n;
    logic [3:0] es;
    m_regwrite = '0; m_memtoreg = '0; m_memwrite = '0; m_iord = '0;
    m_regdst = '0; m_pcen = '0; m_irwrite = '0;
    memwrite_cycles = 0;
    for (int k = 0; k < 16; k++) alu_seen[k] = 3'bxxx;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      es = exp_q.pop_front();
      check($sformatf("state[%0d]", i), {28'd0, state}, {28'd0, es});
      m_regwrite[state] |= regwrite;
      m_memtoreg[state] |= memtoreg;
      m_memwrite[state] |= memwrite;
      m_iord[state]     |= iord;
      m_regdst[state]   |= regdst;
      m_pcen[state]     |= pcen;
      m_irwrite[state]  |= irwrite;
      if (memwrite) memwrite_cycles++;
      alu_seen[state] = alucontrol;
      if (i < n - 1) tick();
    end
  endtask

  task automatic drive(input logic [5:0] op_v, input logic [5:0] funct_v, input logic zero_v);
    op = op_v;
    funct = funct_v;
    zero = zero_v;
    #1;
  endtask

  typedef struct {
    logic [5:0] f;
    logic [2:0] alu;
  } rvec_t;

  rvec_t rtab[6];

  initial begin
    rtab[0] = '{6'b100000, 3'b010};
    rtab[1] = '{6'b100010, 3'b110};
    rtab[2] = '{6'b100100, 3'b000};
    rtab[3] = '{6'b100101, 3'b001};
    rtab[4] = '{6'b101010, 3'b111};
    rtab[5] = '{6'b000000, 3'b000};

    rst = 1'b1;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    tick();
    tick();

    cur = "reset";
    check("state", {28'd0, state}, 32'd0);
    check("irwrite", {31'd0, irwrite}, 32'd1);
    check("pcen", {31'd0, pcen}, 32'd1);
    check("alusrcb", {30'd0, alusrcb}, 32'd1);
    check("memwrite", {31'd0, memwrite}, 32'd0);
    rst = 1'b0;

    cur = "lw";
    drive(6'b100011, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    walk();
    check("regwrite_mask", {16'd0, m_regwrite}, 32'h0010);
    check("memtoreg_mask", {16'd0, m_memtoreg}, 32'h0010);
    check("iord_mask", {16'd0, m_iord}, 32'h0008);
    check("memwrite_mask", {16'd0, m_memwrite}, 32'h0000);
    check("alu_fetch", {29'd0, alu_seen[0]}, 32'h2);

    cur = "sw";
    drive(6'b101011, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    walk();
    check("memwrite_mask", {16'd0, m_memwrite}, 32'h0020);
    check("memwrite_cycles", memwrite_cycles, 32'd1);
    check("iord_mask", {16'd0, m_iord}, 32'h0020);
    check("regwrite_mask", {16'd0, m_regwrite}, 32'h0000);

    cur = "beq_taken";
    drive(6'b000100, 6'b0, 1'b1);
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h0101);
    check("alu_branch", {29'd0, alu_seen[8]}, 32'h6);

    cur = "beq_not_taken";
    drive(6'b000100, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h0001);

    foreach (rtab[r]) begin
      cur = $sformatf("rtype_%b", rtab[r].f);
      drive(6'b000000, rtab[r].f, 1'b0);
      exp_q = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      walk();
      check("alu_exec", {29'd0, alu_seen[6]}, {29'd0, rtab[r].alu});
      check("regdst_mask", {16'd0, m_regdst}, 32'h0080);
      check("regwrite_mask", {16'd0, m_regwrite}, 32'h0080);
    end

    cur = "addi";
    drive(6'b001000, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    walk();
    check("regwrite_mask", {16'd0, m_regwrite}, 32'h0400);
    check("regdst_mask", {16'd0, m_regdst}, 32'h0000);

    cur = "j";
    drive(6'b000010, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd11, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h0801);

    cur = "illegal";
    drive(6'b111111, 6'b0, 1'b1);
    exp_q = '{4'd0, 4'd1, 4'd0};
    walk();
    check("writes", {16'd0, m_regwrite | m_memwrite}, 32'h0000);
    check("pcen_mask", {16'd0, m_pcen}, 32'h0001);
    check("irwrite_mask", {16'd0, m_irwrite}, 32'h0001);

`ifdef MULTICYCLE_CTRL_BNE_EN
    cur = "bne_taken";
    drive(6'b000101, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd12, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h1001);
    cur = "bne_not_taken";
    drive(6'b000101, 6'b0, 1'b1);
    exp_q = '{4'd0, 4'd1, 4'd12, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h0001);
`else
    cur = "bne_disabled";
    drive(6'b000101, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd0};
    walk();
    check("pcen_mask", {16'd0, m_pcen}, 32'h0001);
`endif

    cur = "reset_mid";
    drive(6'b100011, 6'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    walk();
    rst = 1'b1;
    tick();
    check("state_after_rst", {28'd0, state}, 32'd0);
    check("regwrite", {31'd0, regwrite}, 32'd0);
    check("irwrite", {31'd0, irwrite}, 32'd1);
    check("pcen", {31'd0, pcen}, 32'd1);
    tick();
    check("state_held", {28'd0, state}, 32'd0);
    rst = 1'b0;
    tick();
    check("state_resume", {28'd0, state}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- No parameters.
- REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-003 SHALL have port op, input, 6 bits: opcode field from the instruction register.
- REQ-004 SHALL have port funct, input, 6 bits: R-type function field from the instruction register.
- REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
- REQ-006 SHALL have port pcen, output, 1 bit: PC register enable.
- REQ-007 SHALL have ports memwrite, irwrite, regwrite, alusrca, iord, memtoreg and regdst, each an output of 1 bit: standard datapath strobes and selects.
- REQ-008 SHALL have ports alusrcb and pcsrc, each an output of 2 bits: ALU B-operand select and next-PC select.
- REQ-009 SHALL have port alucontrol, output, 3 bits: ALU operation.
- REQ-010 SHALL have port state, output, 4 bits: current state code, for debug.

Function
- REQ-011 SHALL be a Moore FSM; every output SHALL decode from the state register alone, except pcen and alucontrol.
- REQ-012 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB and JUMP.
- REQ-013 SHALL implement these transitions:
  - FETCH->DECODE.
  - DECODE on op: lw(100011) and sw(101011)->MEMADR; R(000000)->EXEC; beq(000100)->BRANCH; addi(001000)->ADDIEX; j(000010)->JUMP; any other opcode->FETCH.
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB.
  - EXEC->ALUWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP->FETCH.
- REQ-014 SHALL drive zero on every output not listed for a state.
- REQ-015 SHALL drive, per state:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXEC: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- REQ-016 SHALL compute pcen = pcwrite | (branch & zero) combinationally.
- REQ-017 SHALL decode alucontrol combinationally:
  - aluop 00->010 (add); 01->110 (sub); 11->010.
  - aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->000.
- REQ-018 SHALL take these cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- REQ-019 SHALL assert memwrite for exactly one cycle per sw and never for any other instruction.
- REQ-020 SHALL treat any unused state code as FETCH-equivalent: all outputs 0, next state FETCH.

Reset
- REQ-021 SHALL, with rst=1 at a rising edge, load FETCH regardless of current state, including mid-instruction.
- REQ-022 SHALL, while in reset, hold state=FETCH and therefore present FETCH outputs (irwrite=1, pcen=1); the datapath SHALL qualify its own registers with rst.

Configuration
- REQ-023 SHALL, with MULTICYCLE_CTRL_BNE_EN defined, add state BNEX (code 12), entered from DECODE on op 000101.
- REQ-024 SHALL, in BNEX, drive the BRANCH outputs except branch=0 and a separate nbranch=1, so that pcen = pcwrite | (branch & zero) | (nbranch & ~zero).
- REQ-025 SHALL, without MULTICYCLE_CTRL_BNE_EN, treat op 000101 as illegal (DECODE->FETCH) and hold nbranch at constant 0.

Structure
- REQ-026 SHALL place the state encodings (FETCH=0 through JUMP=11, BNEX=12), the opcode constants, the funct constants and the ALU operation codes in a shared package, mips_ctrl_pkg.
- REQ-027 SHALL place the alucontrol decode in a combinational sub-module, alu_dec, instantiated once.

Verification
- REQ-028 SHALL verify lw: op=100011 after reset -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- REQ-029 SHALL verify sw: op=101011 -> states 0,1,2,5,0; memwrite=1 and iord=1 only in state 5.
- REQ-030 SHALL verify beq: op=000100 with zero=1 -> pcen=1 in BRANCH; with zero=0 -> pcen=0 in BRANCH.
- REQ-031 SHALL verify R-type decode: op=000000, funct=101010 -> alucontrol=111 in EXEC, then regdst=1 and regwrite=1 in ALUWB.
- REQ-032 SHALL verify illegal opcode: op=111111 -> DECODE->FETCH with no write strobe asserted.
- REQ-033 SHALL verify reset mid-operation: rst=1 during MEMRD -> state=0 after the next edge and no MEMWB regwrite.
